hline_rr_sched: RTL and testbench
=================================

HLINE_RR_SCHED -- requirements
Module: hline_rr_sched

Interface
REQ-001 Parameter CORDW, default 10, coordinate width in bits.
REQ-002 Parameter NREQ, default 4, number of span requesters (2..8).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  level request per requester; held until matching ack.
REQ-006 rx0  input  NREQ*CORDW  span endpoint 0 per requester, requester i at bits [i*CORDW +: CORDW].
REQ-007 rx1  input  NREQ*CORDW  span endpoint 1 per requester, same packing.
REQ-008 ry  input  NREQ*CORDW  span row per requester, same packing.
REQ-009 oe  input  1  output enable; pixel advance only when high.
REQ-010 ack  output  NREQ  one-cycle pulse: request i accepted, operands latched.
REQ-011 x  output  CORDW  current pixel column.
REQ-012 y  output  CORDW  current pixel row.
REQ-013 gid  output  $clog2(NREQ)  index of requester owning the current span.
REQ-014 drawing  output  1  x,y valid pixel this cycle (combinational: state==DRAW && oe).
REQ-015 busy  output  1  high while a span is owned (DRAW state).
REQ-016 done  output  NREQ  one-cycle pulse: span of requester i completed.

Function
REQ-017 States IDLE, DRAW, DONE; no other states.
REQ-018 IDLE: if any req bit high, register winner per round-robin, next state DRAW; else stay.
REQ-019 Round-robin: search starts at index ptr, ascending, wrapping NREQ-1 -> 0; first high req wins.
REQ-020 On grant, ptr <= winner+1 modulo NREQ.
REQ-021 On grant, latch x <= min(rx0,rx1), xend <= max(rx0,rx1), y <= ry, gid <= winner (unsigned compare).
REQ-022 ack[winner] high exactly in first DRAW cycle; all other ack bits low always otherwise.
REQ-023 DRAW with oe high: if x==xend, next state DONE; else x <= x+1.
REQ-024 DRAW with oe low: x, y, state hold; drawing low.
REQ-025 Span of n = xend-xstart+1 pixels produces exactly n drawing cycles; x0==x1 gives one.
REQ-026 x never wraps: xend=2^CORDW-1 terminates at that value without overflow.
REQ-027 DONE: done[gid] high for this one cycle, busy low, next state IDLE.
REQ-028 Latency: req seen in IDLE at cycle n -> DRAW/ack at n+1; last pixel at m -> done at m+1 -> earliest next DRAW at m+3.
REQ-029 req changes during DRAW/DONE ignored; rx0/rx1/ry sampled only at grant.
REQ-030 req still high after ack is treated as a new request at next IDLE.

Reset
REQ-031 rst overrides all other events in the same cycle, including mid-span.
REQ-032 Reset values: state IDLE, ptr 0, x 0, y 0, gid 0, xend 0, ack 0, done 0, busy 0.
REQ-033 Reset mid-span emits no done pulse for the aborted span.

Structure
REQ-034 Package gfx_pkg holds CORDW default and the state enum type.
REQ-035 One sub-module rr_arbiter: req vector + ptr -> one-hot grant + index, combinational.

Verification
REQ-036 Reset, req=0001, rx0=5, rx1=8, ry=3, oe=1 -> ack[0] one cycle, x=5,6,7,8 with y=3, then done[0] one cycle.
REQ-037 rx0=20, rx1=17 -> x=17..20, four drawing cycles, done after last.
REQ-038 req=1111 held, all single-pixel spans -> grant order 0,1,2,3,0; each ack/done once per span.
REQ-039 oe toggling 1,0,1,0 on span 0..2 -> x holds when oe=0, exactly three drawing cycles.
REQ-040 CORDW=10, rx0=1022, rx1=1023 -> x=1022,1023, DONE, no wrap to 0.
REQ-041 rst asserted at second pixel of span 10..30 -> IDLE, busy=0, no done pulse, ptr=0.

Source files
------------

// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_pkg
//  Description : Shared graphics definitions: default coordinate width and
//                the span scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gfx_pkg;

    localparam int CORDW_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches upward from
//                ptr_i, wrapping at NREQ-1, and reports the first active
//                request as a one-hot grant plus its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import gfx_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            any_o,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    // Walk offsets from farthest to nearest so the nearest active request
    // (lowest offset from ptr) is the last assignment and therefore wins.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int p;
            p = int'(ptr_i) + k;
            if (p >= NREQ) begin
                p = p - NREQ;
            end
            if (req_i[p]) begin
                any_o    = 1'b1;
                grant_o  = '0;
                grant_o[p] = 1'b1;
                idx_o    = IW'(p);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hline_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hline_rr_sched
//  Description : Horizontal-line span scheduler. Round-robin grants one of
//                NREQ requesters, latches its span, steps x from the lower
//                to the upper endpoint while oe is high, then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module hline_rr_sched
    import gfx_pkg::*;
#(
    parameter int CORDW = CORDW_DEF,
    parameter int NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*CORDW-1:0]      rx0,
    input  logic [NREQ*CORDW-1:0]      rx1,
    input  logic [NREQ*CORDW-1:0]      ry,
    input  logic                       oe,
    output logic [NREQ-1:0]            ack,
    output logic [CORDW-1:0]           x,
    output logic [CORDW-1:0]           y,
    output logic [$clog2(NREQ)-1:0]    gid,
    output logic                       drawing,
    output logic                       busy,
    output logic [NREQ-1:0]            done
);

    localparam int IW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [CORDW-1:0] x_q,     x_d;
    logic [CORDW-1:0] xend_q,  xend_d;
    logic [CORDW-1:0] y_q,     y_d;
    logic [IW-1:0]    gid_q,   gid_d;
    logic [NREQ-1:0]  ack_q,   ack_d;

    logic             w_any;
    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic [CORDW-1:0] w_ax, w_bx, w_ry;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .any_o   (w_any),
        .grant_o (w_grant),
        .idx_o   (w_idx)
    );

    // Operands of the current arbitration winner.
    assign w_ax = rx0[int'(w_idx)*CORDW +: CORDW];
    assign w_bx = rx1[int'(w_idx)*CORDW +: CORDW];
    assign w_ry = ry [int'(w_idx)*CORDW +: CORDW];

    // State and datapath registers; reset wins over everything, aborting a span.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            x_q     <= '0;
            xend_q  <= '0;
            y_q     <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            xend_q  <= xend_d;
            y_q     <= y_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic: grant in IDLE, step x in DRAW, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        xend_d  = xend_q;
        y_d     = y_q;
        gid_d   = gid_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d = ST_DRAW;
                    ptr_d   = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
                    x_d     = (w_ax <= w_bx) ? w_ax : w_bx;
                    xend_d  = (w_ax <= w_bx) ? w_bx : w_ax;
                    y_d     = w_ry;
                    gid_d   = w_idx;
                    ack_d   = w_grant;
                end
            end
            ST_DRAW: begin
                // Compare before incrementing so xend at the top of the
                // coordinate range terminates without wrapping.
                if (oe) begin
                    if (x_q == xend_q) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d = x_q + CORDW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion pulse for the owning requester while in DONE.
    always_comb begin
        done = '0;
        if (state_q == ST_DONE) begin
            done[gid_q] = 1'b1;
        end
    end

    assign ack     = ack_q;
    assign x       = x_q;
    assign y       = y_q;
    assign gid     = gid_q;
    assign busy    = (state_q == ST_DRAW);
    assign drawing = (state_q == ST_DRAW) && oe;

endmodule
`default_nettype wire

// File: tb/tb_hline_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hline_rr_sched
//  Description : Scoreboard bench for hline_rr_sched. Stimulus pushes the
//                expected ack, pixel and done events; a negedge monitor pops
//                and compares them whenever the DUT presents one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hline_rr_sched;

    localparam int CORDW = 10;
    localparam int NREQ  = 4;

    typedef struct packed {
        logic [CORDW-1:0] px;
        logic [CORDW-1:0] py;
        logic [1:0]       pg;
    } pix_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CORDW-1:0] rx0, rx1, ry;
    logic                  oe;
    logic [NREQ-1:0]       ack, done;
    logic [CORDW-1:0]      x, y;
    logic [1:0]            gid;
    logic                  drawing, busy;

    int total = 0;
    int bad   = 0;

    logic [NREQ-1:0] exp_ack[$];
    logic [NREQ-1:0] exp_done[$];
    pix_t            exp_pix[$];

    hline_rr_sched #(.CORDW(CORDW), .NREQ(NREQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rx0     (rx0),
        .rx1     (rx1),
        .ry      (ry),
        .oe      (oe),
        .ack     (ack),
        .x       (x),
        .y       (y),
        .gid     (gid),
        .drawing (drawing),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT event is matched against the head of its queue.
    always @(negedge clk) begin
        if (ack != '0) begin
            if (exp_ack.size() == 0) chk("ack_unexpected", 32'(ack), 32'(0));
            else chk("ack", 32'(ack), 32'(exp_ack.pop_front()));
        end
        if (drawing === 1'b1) begin
            if (exp_pix.size() == 0) begin
                chk("pix_unexpected", 32'(x), 32'hFFFF);
            end else begin
                pix_t e;
                e = exp_pix.pop_front();
                chk("pix_x", 32'(x), 32'(e.px));
                chk("pix_y", 32'(y), 32'(e.py));
                chk("pix_gid", 32'(gid), 32'(e.pg));
                chk("busy_draw", 32'(busy), 32'(1));
            end
        end else if (busy === 1'b1 && oe === 1'b0 && exp_pix.size() != 0) begin
            chk("x_hold", 32'(x), 32'(exp_pix[0].px));
        end
        if (done != '0) begin
            if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 32'(0));
            else chk("done", 32'(done), 32'(exp_done.pop_front()));
        end
    end

    task automatic set_span(input int i, input int a, input int b, input int yy);
        rx0[i*CORDW +: CORDW] = CORDW'(a);
        rx1[i*CORDW +: CORDW] = CORDW'(b);
        ry [i*CORDW +: CORDW] = CORDW'(yy);
    endtask

    task automatic push_span(input int i, input int a, input int b, input int yy);
        int lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        exp_ack.push_back(NREQ'(1 << i));
        for (int v = lo; v <= hi; v++) begin
            pix_t p;
            p.px = CORDW'(v);
            p.py = CORDW'(yy);
            p.pg = 2'(i);
            exp_pix.push_back(p);
        end
        exp_done.push_back(NREQ'(1 << i));
    endtask

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        while (ack[i] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (ack[i] !== 1'b1) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    // Wait until every pushed event has been seen and the DUT is idle.
    task automatic drain(input bit tog);
        int n;
        n = 0;
        while ((exp_pix.size() != 0 || exp_ack.size() != 0 || exp_done.size() != 0
                || busy !== 1'b0) && n < 200) begin
            @(posedge clk); #1;
            if (tog) oe = ~oe;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(0), 32'(1));
        oe = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_span(input int i, input int a, input int b, input int yy, input bit tog);
        set_span(i, a, b, yy);
        push_span(i, a, b, yy);
        req[i] = 1'b1;
        @(posedge clk); #1;
        wait_ack(i);
        req[i] = 1'b0;
        drain(tog);
    endtask

    initial begin
        int nd;
        rst = 1'b1; req = '0; oe = 1'b1; rx0 = '0; rx1 = '0; ry = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_x", 32'(x), 32'(0));
        chk("rst_y", 32'(y), 32'(0));
        chk("rst_gid", 32'(gid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_drawing", 32'(drawing), 32'(0));

        run_span(0, 5, 8, 3, 1'b0);        // basic span, ptr -> 1
        run_span(1, 20, 17, 9, 1'b0);      // reversed endpoints, ptr -> 2
        run_span(2, 0, 2, 11, 1'b1);       // oe toggling, ptr -> 3
        run_span(3, 1022, 1023, 5, 1'b0);  // top of range, ptr -> 0

        // All requesters held high with single-pixel spans: order 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_span(i, i + 40, i + 40, i + 60);
        push_span(0, 40, 40, 60);
        push_span(1, 41, 41, 61);
        push_span(2, 42, 42, 62);
        push_span(3, 43, 43, 63);
        push_span(0, 40, 40, 60);
        req = 4'b1111;
        nd = 0;
        for (int n = 0; n < 100 && nd < 5; n++) begin
            @(posedge clk); #1;
            if (done != '0) nd++;
        end
        req = '0;
        if (nd < 5) chk("rr_timeout", 32'(nd), 32'(5));
        drain(1'b0);

        // Reset during the second pixel of span 10..30 on requester 2.
        set_span(2, 10, 30, 7);
        exp_ack.push_back(4'b0100);
        begin
            pix_t p;
            p.px = 10'd10; p.py = 10'd7; p.pg = 2'd2; exp_pix.push_back(p);
            p.px = 10'd11; exp_pix.push_back(p);
        end
        req = 4'b0100;
        @(posedge clk); #1;
        wait_ack(2);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_x", 32'(x), 32'(0));
        chk("abort_gid", 32'(gid), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_pix_q", 32'(exp_pix.size()), 32'(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_idle", 32'(busy), 32'(0));
        end

        // ptr back to 0: requesters 0 and 3 pending, 0 must win first.
        set_span(0, 4, 4, 4);
        set_span(3, 6, 6, 6);
        push_span(0, 4, 4, 4);
        push_span(3, 6, 6, 6);
        req = 4'b1001;
        @(posedge clk); #1;
        wait_ack(0);
        req = 4'b1000;
        wait_ack(3);
        req = '0;
        drain(1'b0);

        chk("end_ack_q", 32'(exp_ack.size()), 32'(0));
        chk("end_pix_q", 32'(exp_pix.size()), 32'(0));
        chk("end_done_q", 32'(exp_done.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait above never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
